// File: rtl/bridge_read_responder.sv
// Read-back path for one mapped bridge window: each 32-bit bridge read is served as two
// sequential 16-bit reads on the target memory port, assembled big-endian.
module bridge_read_responder #(
   parameter logic [31:0] BASE_ADDRESS   = 32'h0,
   parameter logic [31:0] MAP_ADDRESS    = 32'h0,
   parameter logic [15:0] MAP_LENGTH     = 16'd0,
   parameter int unsigned MEM_ADDR_WIDTH = 24,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [15:0] FILL_DATA      = 16'hDEAD
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [31:0]               bridge_addr,
   input  logic                      bridge_rd,
   output logic [31:0]               bridge_rd_data,
   output logic                      rd_busy,
   output logic                      rd_done,
   output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
   output logic                      mem_rd,
   input  logic                      mem_ready,
   input  logic [15:0]               mem_rd_data,
   input  logic                      mem_rd_valid,
   output logic                      timeout_flag,
   output logic                      overrun_flag,
   input  logic                      flag_clear
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      REQ_HI  = 3'd1,
      WAIT_HI = 3'd2,
      REQ_LO  = 3'd3,
      WAIT_LO = 3'd4,
      DONE    = 3'd5
   } state_t;

   localparam logic [31:0] END_ADDRESS  = BASE_ADDRESS + {16'h0000, MAP_LENGTH};
   localparam logic [7:0]  TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t                    state_r, state_s;
   logic [MEM_ADDR_WIDTH-1:0] hw_r, hw_s;
   logic [MEM_ADDR_WIDTH-1:0] maddr_r, maddr_s;
   logic [15:0]               hi_r, hi_s;
   logic [15:0]               lo_r, lo_s;
   logic [15:0]               half_s;
   logic [7:0]                cnt_r, cnt_s;
   logic [31:0]               data_r, data_s;
   logic                      busy_r, busy_s;
   logic                      done_r, done_s;
   logic                      mrd_r, mrd_s;
   logic                      to_flag_r, to_flag_s;
   logic                      ov_flag_r, ov_flag_s;
   logic                      to_set_s;
   logic                      ov_set_s;

   logic [31:0]               addr_al_s;
   logic [31:0]               off_s;
   logic                      sel_s;
   logic                      unused_bits_s;

   // The low two address bits are dropped before both the window compare and the offset.
   assign addr_al_s     = {bridge_addr[31:2], 2'b00};
   assign sel_s         = (MAP_LENGTH != 16'd0) && (addr_al_s >= BASE_ADDRESS) && (addr_al_s < END_ADDRESS);
   assign off_s         = addr_al_s - BASE_ADDRESS + MAP_ADDRESS;
   assign unused_bits_s = ^{bridge_addr[1:0], off_s[0], off_s[31:MEM_ADDR_WIDTH+1]};

   // Next-state, datapath and registered-output values for the read sequencer.
   always_comb begin
      state_s  = state_r;
      hw_s     = hw_r;
      maddr_s  = maddr_r;
      hi_s     = hi_r;
      lo_s     = lo_r;
      half_s   = 16'h0000;
      cnt_s    = cnt_r;
      data_s   = data_r;
      busy_s   = busy_r;
      done_s   = 1'b0;
      mrd_s    = mrd_r;
      to_set_s = 1'b0;
      ov_set_s = bridge_rd && sel_s && (state_r != IDLE);

      case (state_r)
         IDLE: begin
            if (bridge_rd && sel_s) begin
               hw_s    = off_s[MEM_ADDR_WIDTH:1];
               maddr_s = off_s[MEM_ADDR_WIDTH:1];
               mrd_s   = 1'b1;
               busy_s  = 1'b1;
               state_s = REQ_HI;
            end else begin
               state_s = IDLE;
            end
         end
         REQ_HI, REQ_LO: begin
            if (mem_ready) begin
               mrd_s   = 1'b0;
               cnt_s   = 8'd0;
               state_s = (state_r == REQ_HI) ? WAIT_HI : WAIT_LO;
            end else begin
               state_s = state_r;
            end
         end
         WAIT_HI, WAIT_LO: begin
            // A missing response is replaced by FILL_DATA so the bridge read always completes.
            if (mem_rd_valid || (cnt_r == TIMEOUT_LAST)) begin
               half_s   = mem_rd_valid ? mem_rd_data : FILL_DATA;
               to_set_s = !mem_rd_valid;
               if (state_r == WAIT_HI) begin
                  hi_s    = half_s;
                  maddr_s = hw_r + MEM_ADDR_WIDTH'(1);
                  mrd_s   = 1'b1;
                  state_s = REQ_LO;
               end else begin
                  lo_s    = half_s;
                  state_s = DONE;
               end
            end else begin
               cnt_s = cnt_r + 8'd1;
            end
         end
         DONE: begin
            data_s  = {hi_r, lo_r};
            done_s  = 1'b1;
            busy_s  = 1'b0;
            state_s = IDLE;
         end
         default: begin
            mrd_s   = 1'b0;
            busy_s  = 1'b0;
            state_s = IDLE;
         end
      endcase

      // A flag event in the same cycle as flag_clear keeps the flag set.
      if (to_set_s) begin
         to_flag_s = 1'b1;
      end else if (flag_clear) begin
         to_flag_s = 1'b0;
      end else begin
         to_flag_s = to_flag_r;
      end

      if (ov_set_s) begin
         ov_flag_s = 1'b1;
      end else if (flag_clear) begin
         ov_flag_s = 1'b0;
      end else begin
         ov_flag_s = ov_flag_r;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r   <= IDLE;
         hw_r      <= '0;
         maddr_r   <= '0;
         hi_r      <= 16'h0000;
         lo_r      <= 16'h0000;
         cnt_r     <= 8'd0;
         data_r    <= 32'h0000_0000;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         mrd_r     <= 1'b0;
         to_flag_r <= 1'b0;
         ov_flag_r <= 1'b0;
      end else begin
         state_r   <= state_s;
         hw_r      <= hw_s;
         maddr_r   <= maddr_s;
         hi_r      <= hi_s;
         lo_r      <= lo_s;
         cnt_r     <= cnt_s;
         data_r    <= data_s;
         busy_r    <= busy_s;
         done_r    <= done_s;
         mrd_r     <= mrd_s;
         to_flag_r <= to_flag_s;
         ov_flag_r <= ov_flag_s;
      end
   end

   assign bridge_rd_data = data_r;
   assign rd_busy        = busy_r;
   assign rd_done        = done_r;
   assign mem_addr       = maddr_r;
   assign mem_rd         = mrd_r;
   assign timeout_flag   = to_flag_r;
   assign overrun_flag   = ov_flag_r;

endmodule

// File: tb/tb_bridge_read_responder.sv
// Bench for bridge_read_responder: three instances differing only in MAP_ADDRESS share all
// inputs; a cycle-schedule model derives every expected output from the window rules.
module tb_bridge_read_responder;

   localparam logic [31:0] BASE = 32'h1000_0000;
   localparam logic [15:0] LEN  = 16'h0100;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] bridge_addr;
   logic        bridge_rd;
   logic        mem_ready;
   logic [15:0] mem_rd_data;
   logic        mem_rd_valid;
   logic        flag_clear;

   logic [31:0] rdata [3];
   logic        busy  [3];
   logic        done  [3];
   logic [23:0] maddr [3];
   logic        mrd   [3];
   logic        tof   [3];
   logic        ovf   [3];

   int          errors = 0;
   int          checks = 0;
   logic [31:0] last_m;
   logic        tf_m;
   logic        of_m;

   always #5 clk = ~clk;

   bridge_read_responder #(.BASE_ADDRESS(BASE), .MAP_ADDRESS(32'h0000_0000), .MAP_LENGTH(LEN),
      .MEM_ADDR_WIDTH(24), .TIMEOUT_CYCLES(4), .FILL_DATA(16'hDEAD)) u_dut0 (
      .clk(clk), .reset_n(reset_n), .bridge_addr(bridge_addr), .bridge_rd(bridge_rd),
      .bridge_rd_data(rdata[0]), .rd_busy(busy[0]), .rd_done(done[0]), .mem_addr(maddr[0]),
      .mem_rd(mrd[0]), .mem_ready(mem_ready), .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid),
      .timeout_flag(tof[0]), .overrun_flag(ovf[0]), .flag_clear(flag_clear));

   bridge_read_responder #(.BASE_ADDRESS(BASE), .MAP_ADDRESS(32'h01FF_FFFC), .MAP_LENGTH(LEN),
      .MEM_ADDR_WIDTH(24), .TIMEOUT_CYCLES(4), .FILL_DATA(16'hDEAD)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .bridge_addr(bridge_addr), .bridge_rd(bridge_rd),
      .bridge_rd_data(rdata[1]), .rd_busy(busy[1]), .rd_done(done[1]), .mem_addr(maddr[1]),
      .mem_rd(mrd[1]), .mem_ready(mem_ready), .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid),
      .timeout_flag(tof[1]), .overrun_flag(ovf[1]), .flag_clear(flag_clear));

   bridge_read_responder #(.BASE_ADDRESS(BASE), .MAP_ADDRESS(32'h01FF_FFFE), .MAP_LENGTH(LEN),
      .MEM_ADDR_WIDTH(24), .TIMEOUT_CYCLES(4), .FILL_DATA(16'hDEAD)) u_dut2 (
      .clk(clk), .reset_n(reset_n), .bridge_addr(bridge_addr), .bridge_rd(bridge_rd),
      .bridge_rd_data(rdata[2]), .rd_busy(busy[2]), .rd_done(done[2]), .mem_addr(maddr[2]),
      .mem_rd(mrd[2]), .mem_ready(mem_ready), .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid),
      .timeout_flag(tof[2]), .overrun_flag(ovf[2]), .flag_clear(flag_clear));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] map_of(input int k);
      case (k)
         0:       return 32'h0000_0000;
         1:       return 32'h01FF_FFFC;
         default: return 32'h01FF_FFFE;
      endcase
   endfunction

   // Halfword index of the first read: word-aligned byte offset into the target space, halved.
   function automatic logic [23:0] exp_hw(input int k, input logic [31:0] a);
      logic [31:0] t;
      t = ((a & 32'hFFFF_FFFC) - BASE + map_of(k)) >> 1;
      return t[23:0];
   endfunction

   task automatic check_all_zero(input string tag);
      for (int k = 0; k < 3; k++) begin
         chk({tag, "_data"}, rdata[k], 32'h0);
         chk({tag, "_busy"}, 32'(busy[k]), 32'h0);
         chk({tag, "_done"}, 32'(done[k]), 32'h0);
         chk({tag, "_addr"}, 32'(maddr[k]), 32'h0);
         chk({tag, "_mrd"}, 32'(mrd[k]), 32'h0);
         chk({tag, "_tof"}, 32'(tof[k]), 32'h0);
         chk({tag, "_ovf"}, 32'(ovf[k]), 32'h0);
      end
   endtask

   // One bridge read. r = extra cycles mem_ready stays low, d = cycles from acceptance to valid.
   task automatic do_read(input logic [31:0] a, input int r1, input int d1, input int r2, input int d2,
                          input logic [15:0] dhi, input logic [15:0] dlo, input bit to_hi, input bit to_lo,
                          input int ovr_c, input int abort_c);
      int acc1, v1, req2, acc2, v2, done_c, nacc;
      logic [15:0] ehi, elo;
      logic exp_mrd, tev;
      logic [23:0] ea;
      acc1   = 1 + r1;
      v1     = acc1 + (to_hi ? 4 : d1);
      req2   = v1 + 1;
      acc2   = req2 + r2;
      v2     = acc2 + (to_lo ? 4 : d2);
      done_c = v2 + 2;
      nacc   = 0;
      ehi    = to_hi ? 16'hDEAD : dhi;
      elo    = to_lo ? 16'hDEAD : dlo;
      bridge_addr  = a;
      bridge_rd    = 1'b1;
      flag_clear   = 1'b0;
      mem_ready    = 1'($urandom_range(0, 1));
      mem_rd_valid = 1'($urandom_range(0, 1));
      mem_rd_data  = 16'($urandom);
      for (int c = 1; c <= done_c; c++) begin
         if (mrd[0] && mem_ready) nacc++;
         @(posedge clk);
         #1;
         bridge_rd   = 1'b0;
         flag_clear  = 1'b0;
         bridge_addr = $urandom;
         exp_mrd = ((c >= 1) && (c <= acc1)) || ((c >= req2) && (c <= acc2));
         chk("mem_rd", 32'(mrd[0]), 32'(exp_mrd));
         for (int k = 0; k < 3; k++) begin
            if (exp_mrd) begin
               ea = exp_hw(k, a) + ((c >= req2) ? 24'd1 : 24'd0);
               chk("mem_addr", 32'(maddr[k]), 32'(ea));
            end
            if (c == 1) chk("held_data", rdata[k], last_m);
         end
         chk("rd_busy", 32'(busy[0]), 32'(c < done_c));
         chk("rd_done", 32'(done[0]), 32'(c == done_c));
         if (c == abort_c) begin
            #2 reset_n = 1'b0;
            #1;
            check_all_zero("async_rst");
            last_m = 32'h0;
            tf_m   = 1'b0;
            of_m   = 1'b0;
            mem_ready    = 1'b0;
            mem_rd_valid = 1'b0;
            @(negedge clk);
            reset_n = 1'b1;
            @(posedge clk);
            #1;
            return;
         end
         if (c == done_c) begin
            last_m = {ehi, elo};
            for (int k = 0; k < 3; k++) begin
               chk("rd_data", rdata[k], last_m);
               chk("timeout_flag", 32'(tof[k]), 32'(tf_m));
               chk("overrun_flag", 32'(ovf[k]), 32'(of_m));
            end
            chk("mem_accepts", 32'(nacc), 32'd2);
            mem_ready    = 1'b0;
            mem_rd_valid = 1'b0;
            return;
         end
         if (exp_mrd) mem_ready = (c == acc1) || (c == acc2);
         else         mem_ready = 1'($urandom_range(0, 1));
         mem_rd_data = 16'($urandom);
         if (c > acc1 && c <= v1) begin
            mem_rd_valid = (c == v1) && !to_hi;
            if (c == v1) mem_rd_data = dhi;
         end else if (c > acc2 && c <= v2) begin
            mem_rd_valid = (c == v2) && !to_lo;
            if (c == v2) mem_rd_data = dlo;
         end else begin
            mem_rd_valid = 1'($urandom_range(0, 1));
         end
         if (c == ovr_c) begin
            bridge_rd   = 1'b1;
            bridge_addr = BASE + 32'h0000_0040;
            flag_clear  = 1'b1;
         end
         tev = (to_hi && c == v1) || (to_lo && c == v2);
         if (tev) tf_m = 1'b1;
         else if (flag_clear) tf_m = 1'b0;
         if (c == ovr_c) of_m = 1'b1;
         else if (flag_clear) of_m = 1'b0;
      end
   endtask

   task automatic no_read(input logic [31:0] a);
      bridge_addr = a;
      bridge_rd   = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         @(posedge clk);
         #1;
         bridge_rd = 1'b0;
         chk("unsel_mem_rd", 32'(mrd[0]), 32'h0);
         chk("unsel_busy", 32'(busy[0]), 32'h0);
         chk("unsel_done", 32'(done[0]), 32'h0);
      end
      chk("unsel_data", rdata[0], last_m);
      chk("unsel_ovf", 32'(ovf[0]), 32'(of_m));
   endtask

   task automatic clear_flags();
      flag_clear = 1'b1;
      @(posedge clk);
      #1;
      flag_clear = 1'b0;
      tf_m = 1'b0;
      of_m = 1'b0;
      chk("clr_tof", 32'(tof[0]), 32'h0);
      chk("clr_ovf", 32'(ovf[0]), 32'h0);
   endtask

   initial begin
      logic [31:0] a;
      reset_n      = 1'b0;
      bridge_addr  = 32'h0;
      bridge_rd    = 1'b0;
      mem_ready    = 1'b0;
      mem_rd_valid = 1'b0;
      mem_rd_data  = 16'h0;
      flag_clear   = 1'b0;
      last_m       = 32'h0;
      tf_m         = 1'b0;
      of_m         = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      do_read(32'h1000_0010, 0, 1, 0, 1, 16'h1234, 16'h5678, 1'b0, 1'b0, -1, -1);
      do_read(32'h1000_00FC, 0, 1, 0, 1, 16'hA5A5, 16'h0F0F, 1'b0, 1'b0, -1, -1);
      no_read(32'h1000_0100);
      no_read(32'h0FFF_FFFC);
      do_read(32'h1000_0013, 0, 1, 0, 1, 16'hCAFE, 16'hBEEF, 1'b0, 1'b0, -1, -1);
      do_read(32'h1000_0020, 5, 3, 0, 1, 16'h1111, 16'h2222, 1'b0, 1'b0, -1, -1);
      do_read(32'h1000_0010, 0, 1, 0, 1, 16'h1234, 16'h0000, 1'b0, 1'b1, -1, -1);
      no_read(32'h2000_0000);
      chk("tof_sticky", 32'(tof[0]), 32'h1);
      clear_flags();
      do_read(32'h1000_0044, 0, 1, 2, 1, 16'h0000, 16'h7777, 1'b1, 1'b0, -1, -1);
      do_read(32'h1000_0080, 0, 3, 0, 1, 16'h9ABC, 16'hDEF0, 1'b0, 1'b0, 2, -1);
      do_read(32'h1000_0030, 0, 1, 0, 3, 16'h4444, 16'h5555, 1'b0, 1'b0, -1, 4);
      do_read(32'h1000_0000, 0, 1, 0, 1, 16'h6543, 16'h210F, 1'b0, 1'b0, -1, -1);

      for (int i = 0; i < 20; i++) begin
         a = BASE + 32'($urandom_range(0, 255));
         do_read(a, $urandom_range(0, 3), $urandom_range(1, 4), $urandom_range(0, 3), $urandom_range(1, 4),
                 16'($urandom), 16'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0), -1, -1);
         if (i == 10) clear_flags();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
